// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_gen PRBS generator.
//   - lfsr_mode_e : step-mode encoding (Fibonacci / Galois)
//   - *_TAPS_<w>  : maximal-length tap masks for common widths.
//     Fibonacci mask bit i set = state[i] feeds the XOR; feedback enters at MSB.
//     Galois mask is XORed into the right-shifted state when the LSB shifted out is 1.
package lfsr_pkg;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } lfsr_mode_e;

  // x^4+x+1, x^8+x^4+x^3+x^2+1, x^16+x^14+x^13+x^11+1, x^32+x^22+x^2+x+1
  localparam logic [3:0]  FIB_TAPS_4  = 4'h3;
  localparam logic [7:0]  FIB_TAPS_8  = 8'h1D;
  localparam logic [15:0] FIB_TAPS_16 = 16'h6801;
  localparam logic [31:0] FIB_TAPS_32 = 32'h0040_0007;

  localparam logic [3:0]  GAL_TAPS_4  = 4'hC;
  localparam logic [7:0]  GAL_TAPS_8  = 8'hB8;
  localparam logic [15:0] GAL_TAPS_16 = 16'hB400;
  localparam logic [31:0] GAL_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function of the LFSR.
// Ports:
//   state  in  N  current state
//   mode   in  1  0 = Fibonacci, 1 = Galois
//   next   out N  state after one step in the selected mode
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned     N        = 8,
  parameter logic [N-1:0]    FIB_TAPS = N'(FIB_TAPS_8),
  parameter logic [N-1:0]    GAL_TAPS = N'(GAL_TAPS_8)
) (
  input  logic [N-1:0] state,
  input  logic         mode,
  output logic [N-1:0] next
);

  logic fb;

  always_comb begin
    fb   = ^(state & FIB_TAPS);
    next = {fb, state[N-1:1]};
    if (mode == MODE_GAL) begin
      next = (state >> 1) ^ (state[0] ? GAL_TAPS : '0);
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Runtime-configurable LFSR PRBS source with seed load, zero-lockup guard,
// Fibonacci/Galois selection and on-line period measurement.
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   en             advance one step this cycle
//   load, seed     load seed this cycle (wins over en); zero seed forced to 1
//   mode           0 = Fibonacci, 1 = Galois, used on every enabled step
//   out, bit_out   registered state and its LSB (serial PRBS bit)
//   wrap           1-cycle pulse: state came back to the start value
//   period         last measured period in steps; period_valid qualifies it
//   lock_err       1-cycle pulse: a zero seed was rejected
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned     N        = 8,
  parameter logic [N-1:0]    FIB_TAPS = N'(FIB_TAPS_8),
  parameter logic [N-1:0]    GAL_TAPS = N'(GAL_TAPS_8),
  parameter logic [N-1:0]    SEED_RST = N'(1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         mode,
  output logic [N-1:0] out,
  output logic         bit_out,
  output logic         wrap,
  output logic [N-1:0] period,
  output logic         period_valid,
  output logic         lock_err
);

  logic [N-1:0] state_q, state_d;
  logic [N-1:0] start_q, start_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] period_q, period_d;
  logic         pv_q, pv_d;
  logic         wrap_q, wrap_d;
  logic         lock_q, lock_d;
  logic         mode_q, mode_d;

  logic [N-1:0] next_state;
  logic         mode_chg;
  logic [N-1:0] start_eff;
  logic [N-1:0] cnt_eff;
  logic [N-1:0] cnt_inc;

  lfsr_next #(
    .N        (N),
    .FIB_TAPS (FIB_TAPS),
    .GAL_TAPS (GAL_TAPS)
  ) u_next (
    .state (state_q),
    .mode  (mode),
    .next  (next_state)
  );

  // A mode switch restarts the measurement from the pre-step state, so the
  // switching step itself is the first counted step of the new cycle.
  assign mode_chg  = (mode != mode_q);
  assign start_eff = mode_chg ? state_q : start_q;
  assign cnt_eff   = mode_chg ? '0 : cnt_q;
  assign cnt_inc   = (cnt_eff == '1) ? cnt_eff : cnt_eff + N'(1);

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = pv_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
    lock_d   = 1'b0;
    if (load) begin
      if (seed == '0) begin
        state_d = N'(1);
        start_d = N'(1);
        lock_d  = 1'b1;
      end else begin
        state_d = seed;
        start_d = seed;
      end
      cnt_d = '0;
      pv_d  = 1'b0;
    end else if (en) begin
      mode_d  = mode;
      state_d = next_state;
      start_d = start_eff;
      pv_d    = mode_chg ? 1'b0 : pv_q;
      if (next_state == start_eff) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        pv_d     = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEED_RST;
      start_q  <= SEED_RST;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      wrap_q   <= 1'b0;
      lock_q   <= 1'b0;
      mode_q   <= MODE_FIB;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      wrap_q   <= wrap_d;
      lock_q   <= lock_d;
      mode_q   <= mode_d;
    end
  end

  assign out          = state_q;
  assign bit_out      = state_q[0];
  assign wrap         = wrap_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign lock_err     = lock_q;

  // A tap mask whose feedback can map a nonzero state to zero is a parameter error.
  a_step_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
    (en && !load) |-> (next_state != '0));
  a_state_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
    state_q != '0);

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       en8, load8, mode8, bit8, wrap8, pv8, lock8;
  logic [7:0] seed8, out8, period8;
  logic       en4, load4, mode4, bit4, wrap4, pv4, lock4;
  logic [3:0] seed4, out4, period4;

  lfsr_gen #(.N(8), .FIB_TAPS(8'h1D), .GAL_TAPS(8'hB8), .SEED_RST(8'h01)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .load(load8), .seed(seed8), .mode(mode8),
    .out(out8), .bit_out(bit8), .wrap(wrap8), .period(period8),
    .period_valid(pv8), .lock_err(lock8));

  lfsr_gen #(.N(4), .FIB_TAPS(4'h3), .GAL_TAPS(4'hC), .SEED_RST(4'h1)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .load(load4), .seed(seed4), .mode(mode4),
    .out(out4), .bit_out(bit4), .wrap(wrap4), .period(period4),
    .period_valid(pv4), .lock_err(lock4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model of the 8-bit instance
  typedef struct {
    logic [7:0] out;
    logic       wrap;
    logic [7:0] period;
    logic       pv;
    logic       lock;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] m_state, m_start, m_cnt, m_period;
  logic       m_pv, m_mode;

  function automatic logic [7:0] fib8(input logic [7:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[4];
    return {fb, s[7:1]};
  endfunction

  function automatic logic [7:0] gal8(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_state = 8'h01; m_start = 8'h01; m_cnt = 8'h00; m_period = 8'h00;
    m_pv = 1'b0; m_mode = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic e, input logic l, input logic [7:0] sd, input logic md);
    exp_t x;
    logic [7:0] nxt;
    x.wrap = 1'b0;
    x.lock = 1'b0;
    if (l) begin
      if (sd == 8'h00) begin
        m_state = 8'h01; m_start = 8'h01; x.lock = 1'b1;
      end else begin
        m_state = sd; m_start = sd;
      end
      m_cnt = 8'h00;
      m_pv  = 1'b0;
    end else if (e) begin
      if (md != m_mode) begin
        m_start = m_state; m_cnt = 8'h00; m_pv = 1'b0; m_mode = md;
      end
      nxt = md ? gal8(m_state) : fib8(m_state);
      m_state = nxt;
      if (nxt == m_start) begin
        x.wrap = 1'b1; m_period = m_cnt + 8'd1; m_pv = 1'b1; m_cnt = 8'h00;
      end else begin
        m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      end
    end
    x.out = m_state; x.period = m_period; x.pv = m_pv;
    sb_q.push_back(x);
  endtask

  task automatic cyc8(input logic e, input logic l, input logic [7:0] sd, input logic md);
    exp_t x;
    en8 = e; load8 = l; seed8 = sd; mode8 = md;
    model_step(e, l, sd, md);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk("sb_out",      32'(out8),    32'(x.out));
    chk("sb_bit_out",  32'(bit8),    32'(x.out[0]));
    chk("sb_wrap",     32'(wrap8),   32'(x.wrap));
    chk("sb_period",   32'(period8), 32'(x.period));
    chk("sb_pvalid",   32'(pv8),     32'(x.pv));
    chk("sb_lock_err", 32'(lock8),   32'(x.lock));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] seed;
    logic       mode;
    logic [7:0] exp_out;
    logic       exp_lock;
  } vec_t;
  vec_t vecs[11];

  initial begin
    logic seen[16];
    int   nseen, steps, wraps;
    logic e;

    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h80, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h88, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hC4, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h01, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h52, 1'b0};

    rst_n = 1'b0;
    en8 = 1'b0; load8 = 1'b0; seed8 = 8'h00; mode8 = 1'b0;
    en4 = 1'b0; load4 = 1'b0; seed4 = 4'h0; mode4 = 1'b0;
    model_reset();
    #12;
    chk("rst_out",      32'(out8),    32'h01);
    chk("rst_bit_out",  32'(bit8),    32'h1);
    chk("rst_wrap",     32'(wrap8),   32'h0);
    chk("rst_period",   32'(period8), 32'h00);
    chk("rst_pvalid",   32'(pv8),     32'h0);
    chk("rst_lock_err", 32'(lock8),   32'h0);
    chk("rst_out4",     32'(out4),    32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // N=4 maximal sequence: wrap every 15 steps, all nonzero states once
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    nseen = 0;
    en4 = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      chk("n4_wrap", 32'(wrap4), 32'((k % 15) == 0));
      chk("n4_bit_out", 32'(bit4), 32'(out4[0]));
      chk("n4_lock_err", 32'(lock4), 32'h0);
      if ((k % 15) == 0) begin
        chk("n4_period", 32'(period4), 32'd15);
        chk("n4_pvalid", 32'(pv4), 32'h1);
        chk("n4_out_at_wrap", 32'(out4), 32'h1);
      end
      if (k <= 15) begin
        chk("n4_nonzero", 32'(out4 == 4'h0), 32'h0);
        chk("n4_unique", 32'(seen[out4]), 32'h0);
        if (!seen[out4]) nseen++;
        seen[out4] = 1'b1;
      end
    end
    en4 = 1'b0;
    chk("n4_visited", 32'(nseen), 32'd15);

    // Table-driven: Fibonacci sequence from reset, zero-seed guard, load priority
    for (int i = 0; i < 11; i++) begin
      cyc8(vecs[i].en, vecs[i].load, vecs[i].seed, vecs[i].mode);
      chk($sformatf("vec%0d_out", i), 32'(out8), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_lock", i), 32'(lock8), 32'(vecs[i].exp_lock));
      if (vecs[i].load) chk($sformatf("vec%0d_pvalid", i), 32'(pv8), 32'h0);
    end

    // Galois from reset: two full periods
    pulse_reset();
    for (int k = 1; k <= 510; k++) begin
      cyc8(1'b1, 1'b0, 8'h00, 1'b1);
      if (k == 1) chk("gal_step1", 32'(out8), 32'hB8);
      if (k == 2) chk("gal_step2", 32'(out8), 32'h5C);
      if ((k % 255) == 0) begin
        chk("gal_wrap", 32'(wrap8), 32'h1);
        chk("gal_period", 32'(period8), 32'd255);
        chk("gal_pvalid", 32'(pv8), 32'h1);
        chk("gal_out_at_wrap", 32'(out8), 32'h01);
      end
    end

    // Random enable gaps, Fibonacci
    pulse_reset();
    steps = 0;
    wraps = 0;
    for (int k = 0; k < 600; k++) begin
      e = ($urandom_range(0, 3) != 0);
      cyc8(e, 1'b0, 8'h00, 1'b0);
      if (e) steps++;
      if (wrap8) begin
        wraps++;
        chk("rand_period", 32'(period8), 32'd255);
        chk("rand_wrap_step", 32'(steps), 32'(255 * wraps));
      end
    end
    chk("rand_wrap_count", 32'(wraps), 32'(steps / 255));

    // Mode flip mid-run
    chk("pvalid_before_flip", 32'(pv8), 32'h1);
    for (int k = 1; k <= 255; k++) begin
      cyc8(1'b1, 1'b0, 8'h00, 1'b1);
      if (k == 1) chk("flip_pvalid_drop", 32'(pv8), 32'h0);
      if (k == 255) begin
        chk("flip_wrap", 32'(wrap8), 32'h1);
        chk("flip_period", 32'(period8), 32'd255);
        chk("flip_pvalid", 32'(pv8), 32'h1);
      end
    end

    // Async reset between edges while a lock_err pulse is showing
    cyc8(1'b1, 1'b1, 8'h00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out",      32'(out8),    32'h01);
    chk("async_wrap",     32'(wrap8),   32'h0);
    chk("async_period",   32'(period8), 32'h00);
    chk("async_pvalid",   32'(pv8),     32'h0);
    chk("async_lock_err", 32'(lock8),   32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc8(1'b0, 1'b0, 8'h00, 1'b0);
    cyc8(1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_step", 32'(out8), 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
